mojo_com_host: RTL and testbench

- Host-side initiator for the mojo_com register-array link over UART.
- Turns single read/write burst requests into the command byte stream the FPGA-side responder consumes, and collects read-response bytes.
- Sits between a test/controller FSM and a serial_interface instance, using the same byte-level ser_* handshake.
- Used in multi-board setups and as the bus-functional driver in mojo_com system benches.

---
 rtl/mojo_com_host.sv | 233 +++++++++++++++++++++++
 tb/tb_mojo_com_host.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mojo_com_host.sv
// mojo_com_host: host-side initiator that turns read/write burst requests into
// mojo_com command bytes. Define MOJO_COM_HOST_CHECKSUM_EN for the XOR checksum byte.

module mojo_com_host #(
  parameter int ADDR_SPACE     = 256,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] ser_tx_data,
  output logic       ser_new_tx_data,
  input  logic       ser_tx_busy,
  input  logic [7:0] ser_rx_data,
  input  logic       ser_new_rx_data,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [7:0] req_addr,
  input  logic [5:0] req_len,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       done,
  output logic       err,
  output logic       busy
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // The idle counter starts at 0 on the cycle after a byte, so DONE lands
  // exactly TIMEOUT_CYCLES cycles after the last received strobe.
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_CMD,
    S_SEND_ADDR,
    S_SEND_DATA,
    S_RECV_DATA,
    S_DONE
`ifdef MOJO_COM_HOST_CHECKSUM_EN
    , S_SEND_CSUM,
    S_RECV_CSUM
`endif
  } state_e;

  state_e        state_q, state_d;
  logic          write_q, write_d;
  logic [7:0]    addr_q, addr_d;
  logic [5:0]    len_q, len_d;
  logic [6:0]    cnt_q, cnt_d;
  logic [TW-1:0] to_q, to_d;
  logic          err_q, err_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_stb_q, tx_stb_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
`ifdef MOJO_COM_HOST_CHECKSUM_EN
  logic [7:0]    csum_q, csum_d;
`endif

  logic [9:0] end_addr;
  logic       addr_bad;
  logic       tx_ok;
  logic       last_byte;
  logic       to_hit;

  assign end_addr  = {2'b00, req_addr} + {4'b0000, req_len} + 10'd1;
  assign addr_bad  = int'(end_addr) > ADDR_SPACE;
  // The previous-strobe guard covers the cycle before the UART raises busy.
  assign tx_ok     = !ser_tx_busy && !tx_stb_q;
  assign last_byte = (cnt_q == {1'b0, len_q});
  assign to_hit    = (to_q == TO_LAST);

  assign ser_tx_data     = tx_data_q;
  assign ser_new_tx_data = tx_stb_q;
  assign rd_data         = rd_data_q;
  assign rd_valid        = rd_valid_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      write_q    <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      to_q       <= '0;
      err_q      <= 1'b0;
      tx_data_q  <= '0;
      tx_stb_q   <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
`ifdef MOJO_COM_HOST_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      to_q       <= to_d;
      err_q      <= err_d;
      tx_data_q  <= tx_data_d;
      tx_stb_q   <= tx_stb_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
`ifdef MOJO_COM_HOST_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  // NOTE: every signal gets a default before the case so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    addr_d     = addr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    to_d       = to_q;
    err_d      = err_q;
    tx_data_d  = tx_data_q;
    tx_stb_d   = 1'b0;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
`ifdef MOJO_COM_HOST_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    req_ready  = 1'b0;
    wr_ready   = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    busy       = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          len_d   = req_len;
          cnt_d   = '0;
          to_d    = '0;
          err_d   = addr_bad;
`ifdef MOJO_COM_HOST_CHECKSUM_EN
          csum_d  = {req_write, 1'b0, req_len} ^ req_addr;
`endif
          state_d = addr_bad ? S_DONE : S_SEND_CMD;
        end
      end
      S_SEND_CMD: begin
        if (tx_ok) begin
          tx_stb_d  = 1'b1;
          tx_data_d = {write_q, 1'b0, len_q};
          state_d   = S_SEND_ADDR;
        end
      end
      S_SEND_ADDR: begin
        if (tx_ok) begin
          tx_stb_d  = 1'b1;
          tx_data_d = addr_q;
          to_d      = '0;
          state_d   = write_q ? S_SEND_DATA : S_RECV_DATA;
        end
      end
      S_SEND_DATA: begin
        wr_ready = tx_ok;
        if (wr_valid && tx_ok) begin
          tx_stb_d  = 1'b1;
          tx_data_d = wr_data;
          cnt_d     = cnt_q + 7'd1;
`ifdef MOJO_COM_HOST_CHECKSUM_EN
          csum_d    = csum_q ^ wr_data;
          if (last_byte) state_d = S_SEND_CSUM;
`else
          if (last_byte) state_d = S_DONE;
`endif
        end
      end
      S_RECV_DATA: begin
        if (ser_new_rx_data) begin
          rd_data_d  = ser_rx_data;
          rd_valid_d = 1'b1;
          cnt_d      = cnt_q + 7'd1;
          to_d       = '0;
`ifdef MOJO_COM_HOST_CHECKSUM_EN
          csum_d     = csum_q ^ ser_rx_data;
          if (last_byte) state_d = S_RECV_CSUM;
`else
          if (last_byte) state_d = S_DONE;
`endif
        end else if (to_hit) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
`ifdef MOJO_COM_HOST_CHECKSUM_EN
      S_SEND_CSUM: begin
        if (tx_ok) begin
          tx_stb_d  = 1'b1;
          tx_data_d = csum_q;
          state_d   = S_DONE;
        end
      end
      S_RECV_CSUM: begin
        if (ser_new_rx_data) begin
          err_d   = (ser_rx_data != csum_q);
          state_d = S_DONE;
        end else if (to_hit) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
`endif
      S_DONE: begin
        done    = 1'b1;
        err     = err_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mojo_com_host.sv
// Self-checking bench for mojo_com_host: table vectors, directed corner cases
// and randomized bursts checked against a byte-stream model of the link.

module tb_mojo_com_host;

  localparam int ADDR_SPACE = 256;
  localparam int TIMEOUT    = 50;
`ifdef MOJO_COM_HOST_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ser_tx_data;
  logic       ser_new_tx_data;
  logic       ser_tx_busy = 1'b0;
  logic [7:0] ser_rx_data = '0;
  logic       ser_new_rx_data = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_write = 1'b0;
  logic [7:0] req_addr = '0;
  logic [5:0] req_len = '0;
  logic [7:0] wr_data = '0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       done;
  logic       err;
  logic       busy;

  always #5 clk = ~clk;

  mojo_com_host #(.ADDR_SPACE(ADDR_SPACE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .ser_tx_data(ser_tx_data), .ser_new_tx_data(ser_new_tx_data), .ser_tx_busy(ser_tx_busy),
    .ser_rx_data(ser_rx_data), .ser_new_rx_data(ser_new_rx_data),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .done(done), .err(err), .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Environment: logs DUT output strobes, emulates UART busy, counts guard violations.
  logic [7:0] tx_log[$];
  logic [7:0] rd_log[$];
  int done_cnt = 0;
  bit last_done_err = 1'b0;
  int done_cyc = 0;
  int guard_viol = 0;
  int busy_hold = 0;
  int busy_left = 0;
  bit busy_pend = 1'b0;
  bit prev_stb = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      busy_left   = 0;
      busy_pend   = 1'b0;
      ser_tx_busy = 1'b0;
      prev_stb    = 1'b0;
    end else begin
      if (ser_new_tx_data) begin
        if (ser_tx_busy || prev_stb) guard_viol++;
        tx_log.push_back(ser_tx_data);
      end
      if (rd_valid) rd_log.push_back(rd_data);
      if (done) begin
        done_cnt++;
        last_done_err = err;
        done_cyc = cyc;
      end
      if (busy_pend) begin
        busy_pend   = 1'b0;
        ser_tx_busy = 1'b1;
        busy_left   = busy_hold;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) ser_tx_busy = 1'b0;
      end
      if (ser_new_tx_data && busy_hold > 0) busy_pend = 1'b1;
      prev_stb = ser_new_tx_data;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  logic [7:0] payload[$];
  int req_cyc = 0;
  int last_rx_cyc = 0;
  bit obs_err = 1'b0;
  int obs_ntx = 0;

  task automatic send_req(input bit wr, input logic [7:0] addr, input logic [5:0] len);
    @(negedge clk);
    check("req_ready_in_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_len   = len;
    req_cyc   = cyc;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic feed_byte(input logic [7:0] b, input int gap, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    repeat (gap) @(negedge clk);
    wr_data  = b;
    wr_valid = 1'b1;
    for (int t = 0; t < 2000; t++) begin
      #1;
      if (wr_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    #1 wr_valid = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    @(negedge clk);
    ser_rx_data     = b;
    ser_new_rx_data = 1'b1;
    last_rx_cyc     = cyc;
    @(negedge clk);
    ser_new_rx_data = 1'b0;
  endtask

  // Model: the link is a list of bytes; expectations are built from the
  // request fields and payload, then compared with what the monitor logged.
  task automatic run_txn(input string nm, input bit wr, input logic [7:0] addr,
                         input logic [5:0] len, input int n_resp, input int hold,
                         input bit csum_bad, input bit rand_gaps);
    bit bad;
    bit exp_err;
    bit ok;
    logic [7:0] cmd;
    logic [7:0] cs;
    logic [7:0] exp_tx[$];
    logic [7:0] exp_rd[$];
    int tx0, rd0, d0, g0, nb;

    nb  = int'(len) + 1;
    bad = (int'(addr) + nb) > ADDR_SPACE;
    cmd = {wr, 1'b0, len};
    exp_err = bad;
    cs = cmd ^ addr;
    if (!bad) begin
      exp_tx.push_back(cmd);
      exp_tx.push_back(addr);
      if (wr) begin
        for (int i = 0; i < nb; i++) begin
          exp_tx.push_back(payload[i]);
          cs ^= payload[i];
        end
        if (CSUM_EN) exp_tx.push_back(cs);
      end else begin
        for (int i = 0; i < n_resp && i < nb; i++) begin
          exp_rd.push_back(payload[i]);
          cs ^= payload[i];
        end
        if (n_resp < nb) exp_err = 1'b1;
        else if (CSUM_EN && csum_bad) exp_err = 1'b1;
      end
    end

    busy_hold = hold;
    tx0 = tx_log.size();
    rd0 = rd_log.size();
    d0  = done_cnt;
    g0  = guard_viol;

    send_req(wr, addr, len);
    if (!bad) begin
      if (wr) begin
        for (int i = 0; i < nb; i++) begin
          feed_byte(payload[i], rand_gaps ? int'($urandom_range(0, 2)) : 0, ok);
          if (!ok) begin
            check({nm, " wr_ready_wait"}, 32'd0, 32'd1);
            break;
          end
        end
      end else begin
        for (int t = 0; t < 3000; t++) begin
          if (tx_log.size() >= tx0 + 2) break;
          @(negedge clk);
        end
        for (int k = 0; k < n_resp; k++)
          rx_byte(payload[k], rand_gaps ? int'($urandom_range(0, 3)) : 0);
        if (CSUM_EN && n_resp == nb) rx_byte(csum_bad ? (cs ^ 8'h11) : cs, 0);
      end
    end

    for (int t = 0; t < 3000 && done_cnt == d0; t++) @(negedge clk);
    @(negedge clk);
    check({nm, " done_pulses"}, 32'(done_cnt - d0), 32'd1);
    check({nm, " req_ready_after_done"}, 32'(req_ready), 32'd1);
    check({nm, " err"}, 32'(last_done_err), 32'(exp_err));
    check({nm, " tx_count"}, 32'(tx_log.size() - tx0), 32'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size() && tx0 + i < tx_log.size(); i++)
      check($sformatf("%s tx[%0d]", nm, i), 32'(tx_log[tx0 + i]), 32'(exp_tx[i]));
    check({nm, " rd_count"}, 32'(rd_log.size() - rd0), 32'(exp_rd.size()));
    for (int i = 0; i < exp_rd.size() && rd0 + i < rd_log.size(); i++)
      check($sformatf("%s rd[%0d]", nm, i), 32'(rd_log[rd0 + i]), 32'(exp_rd[i]));
    check({nm, " tx_guard"}, 32'(guard_viol - g0), 32'd0);
    if (bad) check({nm, " bad_addr_latency"}, 32'(done_cyc - req_cyc), 32'd1);
    if (!wr && !bad && n_resp > 0 && n_resp < nb)
      check({nm, " timeout_latency"}, 32'(done_cyc - last_rx_cyc), 32'(TIMEOUT));
    obs_err = last_done_err;
    obs_ntx = tx_log.size() - tx0;
    busy_hold = 0;
  endtask

  typedef struct {
    bit         wr;
    logic [7:0] addr;
    logic [5:0] len;
    int         n_resp;
    int         hold;
    logic [7:0] base;
    logic [7:0] step;
    bit         exp_err;
    int         exp_ntx;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #200_000_0;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int d0, rd0, nr;
    bit w;
    logic [7:0] a;
    logic [5:0] l;

    vecs[0] = '{1'b1, 8'h10, 6'd2,  0,  20, 8'hA1, 8'h11, 1'b0, 5};
    vecs[1] = '{1'b0, 8'h05, 6'd1,  2,  3,  8'h5A, 8'hE2, 1'b0, 2};
    vecs[2] = '{1'b0, 8'h30, 6'd3,  2,  0,  8'h21, 8'h01, 1'b1, 2};
    vecs[3] = '{1'b1, 8'hFE, 6'd3,  0,  0,  8'h00, 8'h01, 1'b1, 0};
    vecs[4] = '{1'b1, 8'hC0, 6'd63, 0,  2,  8'h00, 8'h01, 1'b0, 66};
    vecs[5] = '{1'b0, 8'hC1, 6'd63, 64, 1,  8'h00, 8'h01, 1'b1, 0};
    vecs[6] = '{1'b0, 8'h00, 6'd63, 64, 1,  8'h80, 8'h03, 1'b0, 2};
    vecs[7] = '{1'b1, 8'hFF, 6'd0,  0,  5,  8'h3C, 8'h01, 1'b0, 3};

    #1 rst = 1'b0;
    #3;
    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset ser_new_tx_data", 32'(ser_new_tx_data), 32'd0);
    check("reset ser_tx_data", 32'(ser_tx_data), 32'd0);
    check("reset outputs", {26'd0, wr_ready, rd_valid, done, err, busy, |rd_data}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Responder bytes while idle must be dropped.
    rd0 = rd_log.size();
    rx_byte(8'h77, 0);
    rx_byte(8'h66, 1);
    @(negedge clk);
    check("idle_rx_dropped", 32'(rd_log.size() - rd0), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    for (int v = 0; v < 8; v++) begin
      payload.delete();
      for (int i = 0; i < 64; i++) payload.push_back(8'(vecs[v].base + 8'(i) * vecs[v].step));
      run_txn($sformatf("vec%0d", v), vecs[v].wr, vecs[v].addr, vecs[v].len,
              vecs[v].n_resp, vecs[v].hold, 1'b0, 1'b0);
      check($sformatf("vec%0d table_err", v), 32'(obs_err), 32'(vecs[v].exp_err));
      check($sformatf("vec%0d table_ntx", v), 32'(obs_ntx),
            32'(vecs[v].exp_ntx + ((CSUM_EN && vecs[v].wr && !vecs[v].exp_err) ? 1 : 0)));
    end

    // Reset asserted while the second write data byte is being strobed.
    payload.delete();
    for (int i = 0; i < 64; i++) payload.push_back(8'(8'h11 * (i + 1)));
    busy_hold = 3;
    send_req(1'b1, 8'h40, 6'd3);
    feed_byte(8'h11, 0, ok);
    feed_byte(8'h22, 0, ok);
    check("rst_seq byte2_accepted", 32'(ok), 32'd1);
    d0 = done_cnt;
    #2 rst = 1'b0;
    #1;
    check("rst_mid ser_new_tx_data", 32'(ser_new_tx_data), 32'd0);
    check("rst_mid req_ready", 32'(req_ready), 32'd1);
    check("rst_mid outputs", {27'd0, wr_ready, rd_valid, done, err, busy}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mid no_done", 32'(done_cnt - d0), 32'd0);
    run_txn("after_rst", 1'b1, 8'h40, 6'd3, 0, 3, 1'b0, 1'b0);

`ifdef MOJO_COM_HOST_CHECKSUM_EN
    payload.delete();
    payload.push_back(8'h11);
    run_txn("csum_bad", 1'b0, 8'h00, 6'd0, 1, 0, 1'b1, 1'b0);
    check("csum_bad err", 32'(obs_err), 32'd1);
    run_txn("csum_good", 1'b0, 8'h00, 6'd0, 1, 0, 1'b0, 1'b0);
    check("csum_good err", 32'(obs_err), 32'd0);
`endif

    for (int r = 0; r < 40; r++) begin
      w = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 3) == 0) ? 8'(255 - $urandom_range(0, 70)) : 8'($urandom);
      l = 6'($urandom);
      nr = int'(l) + 1;
      if (l != 0 && $urandom_range(0, 7) == 0) nr = int'($urandom_range(1, int'(l)));
      payload.delete();
      for (int i = 0; i < 64; i++) payload.push_back(8'($urandom));
      run_txn($sformatf("rand%0d", r), w, a, l, w ? 0 : nr, int'($urandom_range(0, 4)),
              ($urandom_range(0, 3) == 0), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
